// File: rtl/sensor_link_emu.sv
// Sensor-side link emulator: decodes serial command frames on cmd and streams
// synthetic pixel lines MSB first on two lanes (even pixels / odd pixels).
module sensor_link_emu #(
    parameter int               PIX_W     = 14,
    parameter int               LINE_PIX  = 640,
    parameter int               GAP_CYC   = 16,
    parameter logic [PIX_W-1:0] SYNC_WORD = 14'h3FC0
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic cmd,
    output logic data_even,
    output logic data_odd,
    output logic busy,
    output logic frame_done,
    output logic cmd_err
);
    localparam int HALF = LINE_PIX / 2;
    localparam int BW   = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(PIX_W - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(HALF - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    localparam logic [3:0] OP_LINES   = 4'h1;
    localparam logic [3:0] OP_PATTERN = 4'h2;
    localparam logic [3:0] OP_CONST   = 4'h3;
    localparam logic [3:0] OP_START   = 4'h4;
    localparam logic [3:0] OP_STOP    = 4'h5;

    typedef enum logic [1:0] {R_IDLE, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SYNC, T_PIX, T_GAP} tx_state_t;

    rx_state_t rx_state, rx_next;
    tx_state_t tx_state, tx_next;

    logic [3:0]       rx_cnt;
    logic [15:0]      rx_shift;
    logic             cmd_prev;
    logic             exec_v;
    logic [15:0]      exec_word;
    logic             frame_err;
    logic [3:0]       op;
    logic [11:0]      arg;
    logic             illegal, exec_ok, start_now, tx_idle, frame_end;
    logic [11:0]      lines_reg;
    logic [1:0]       pattern, act_pat;
    logic [PIX_W-1:0] const_reg, act_const;
    logic             stop_pend;
    logic [BW-1:0]    bit_cnt, sel;
    logic [PW-1:0]    pix_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [11:0]      line_cnt;
    logic             bit_last, pix_last, gap_last, line_last;
    logic [PW:0]      p_even, p_odd;
    logic [PIX_W-1:0] word_e, word_o;
    logic             lane_e, lane_o;

    // A start needs a falling edge on cmd, so a line held low after a bad stop bit
    // cannot re-trigger until it has been seen high.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (!cmd && cmd_prev) rx_next = R_DATA;
            R_DATA:  if (rx_cnt == 4'd15) rx_next = R_STOP;
            R_STOP:  rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
        if (!ena) rx_next = R_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= R_IDLE;
            rx_cnt    <= '0;
            rx_shift  <= '0;
            cmd_prev  <= 1'b0;
            exec_v    <= 1'b0;
            exec_word <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_next;
            cmd_prev  <= cmd;
            exec_v    <= 1'b0;
            frame_err <= 1'b0;
            if (rx_state == R_DATA) begin
                rx_shift <= {rx_shift[14:0], cmd};
                rx_cnt   <= rx_cnt + 1'b1;
            end else begin
                rx_cnt <= '0;
            end
            if (rx_state == R_STOP && ena) begin
                if (cmd) begin
                    exec_v    <= 1'b1;
                    exec_word <= rx_shift;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign op      = exec_word[15:12];
    assign arg     = exec_word[11:0];
    assign tx_idle = (tx_state == T_IDLE);

    always_comb begin
        illegal = 1'b0;
        case (op)
            OP_LINES:         illegal = (arg == 12'd0) || !tx_idle;
            OP_PATTERN:       illegal = (arg[1:0] == 2'd3);
            OP_CONST, OP_STOP: illegal = 1'b0;
            OP_START:         illegal = !tx_idle;
            default:          illegal = 1'b1;
        endcase
    end

    assign exec_ok   = exec_v && ena && !illegal;
    assign start_now = exec_ok && (op == OP_START);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_reg <= 12'd1;
            pattern   <= 2'd0;
            const_reg <= '0;
            stop_pend <= 1'b0;
        end else begin
            if (frame_end || !ena) stop_pend <= 1'b0;
            else if (exec_ok && op == OP_STOP && !tx_idle) stop_pend <= 1'b1;
            if (exec_ok) begin
                case (op)
                    OP_LINES:   lines_reg <= arg;
                    OP_PATTERN: pattern   <= arg[1:0];
                    OP_CONST:   const_reg <= PIX_W'(arg);
                    default:    ;
                endcase
            end
        end
    end

    assign bit_last  = (bit_cnt == BIT_LAST);
    assign pix_last  = (pix_cnt == PIX_LAST);
    assign gap_last  = (gap_cnt == GAP_LAST);
    assign line_last = (line_cnt == lines_reg - 12'd1);
    assign frame_end = ena && (tx_state == T_GAP) && gap_last && (line_last || stop_pend);

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  if (start_now) tx_next = T_SYNC;
            T_SYNC:  if (bit_last) tx_next = T_PIX;
            T_PIX:   if (bit_last && pix_last) tx_next = T_GAP;
            T_GAP:   if (gap_last) tx_next = (line_last || stop_pend) ? T_IDLE : T_SYNC;
            default: tx_next = T_IDLE;
        endcase
        if (!ena) tx_next = T_IDLE;
    end

    // Pattern and constant are sampled only on entry to SYNC so a line never changes mid-way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state   <= T_IDLE;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            gap_cnt    <= '0;
            line_cnt   <= '0;
            act_pat    <= 2'd0;
            act_const  <= '0;
            frame_done <= 1'b0;
        end else begin
            tx_state   <= tx_next;
            frame_done <= frame_end;
            if (tx_next == T_SYNC && tx_state != T_SYNC) begin
                act_pat   <= pattern;
                act_const <= const_reg;
            end
            case (tx_state)
                T_SYNC: bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                T_PIX: begin
                    bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                    if (bit_last) pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
                end
                T_GAP: begin
                    gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
                    if (gap_last) line_cnt <= line_cnt + 1'b1;
                end
                default: begin
                    bit_cnt  <= '0;
                    pix_cnt  <= '0;
                    gap_cnt  <= '0;
                    line_cnt <= '0;
                end
            endcase
            if (!ena) begin
                bit_cnt  <= '0;
                pix_cnt  <= '0;
                gap_cnt  <= '0;
                line_cnt <= '0;
            end
        end
    end

    assign p_even = {pix_cnt, 1'b0};
    assign p_odd  = {pix_cnt, 1'b1};

    always_comb begin
        sel    = BIT_LAST - bit_cnt;
        word_e = '0;
        word_o = '0;
        case (act_pat)
            2'd0: begin
                word_e = PIX_W'(p_even);
                word_o = PIX_W'(p_odd);
            end
            2'd1: begin
                word_e = act_const;
                word_o = act_const;
            end
            2'd2: begin
                word_e = {PIX_W{line_cnt[0]}};
                word_o = {PIX_W{~line_cnt[0]}};
            end
            default: ;
        endcase
        lane_e = 1'b0;
        lane_o = 1'b0;
        if (tx_state == T_SYNC) begin
            lane_e = SYNC_WORD[sel];
            lane_o = SYNC_WORD[sel];
        end else if (tx_state == T_PIX) begin
            lane_e = word_e[sel];
            lane_o = word_o[sel];
        end
    end

    assign data_even = ena && lane_e;
    assign data_odd  = ena && lane_o;
    assign busy      = ena && (!tx_idle || start_now);
    assign cmd_err   = ena && (frame_err || (exec_v && illegal));

endmodule

// File: tb/tb_sensor_link_emu.sv
// Directed bench for sensor_link_emu with LINE_PIX=4, PIX_W=14, GAP_CYC=2 (44-cycle lines).
module tb_sensor_link_emu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic cmd = 1'b1;
    logic data_even, data_odd, busy, frame_done, cmd_err;

    int checks   = 0;
    int failures = 0;

    bit le[0:511];
    bit lo[0:511];
    int done_off;

    sensor_link_emu #(
        .PIX_W(14), .LINE_PIX(4), .GAP_CYC(2), .SYNC_WORD(14'h3FC0)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .cmd(cmd),
        .data_even(data_even), .data_odd(data_odd),
        .busy(busy), .frame_done(frame_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle after the stop bit was sampled (command execution cycle).
    task automatic send(input logic [15:0] word, input logic stop_bit);
        cmd = 1'b0;
        step();
        for (int i = 15; i >= 0; i--) begin
            cmd = word[i];
            step();
        end
        cmd = stop_bit;
        step();
        cmd = 1'b1;
    endtask

    // Records both lanes from the first sync bit onward until frame_done or budget;
    // optionally shifts out a STOP command starting at offset stop_at.
    task automatic capture(input int budget, input int stop_at);
        logic [17:0] sb;
        sb = {1'b0, 16'h5000, 1'b1};
        done_off = -1;
        for (int j = 0; j < budget; j++) begin
            step();
            le[j] = data_even;
            lo[j] = data_odd;
            if (stop_at >= 0 && j >= stop_at && j < stop_at + 18) cmd = sb[17 - (j - stop_at)];
            else cmd = 1'b1;
            if (frame_done) begin
                done_off = j;
                break;
            end
        end
        cmd = 1'b1;
    endtask

    function automatic logic [13:0] word_at(input int lane, input int off);
        logic [13:0] w;
        w = '0;
        for (int i = 0; i < 14; i++) w = {w[12:0], (lane == 1) ? lo[off + i] : le[off + i]};
        return w;
    endfunction

    function automatic logic [13:0] exp_pix(input int pat, input logic [13:0] cval,
                                            input int l, input int p);
        if (pat == 0) return 14'(p);
        if (pat == 1) return cval;
        return (((l ^ p) & 1) != 0) ? 14'h3FFF : 14'h0000;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if ({data_even, data_odd, busy, frame_done, cmd_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {data_even, data_odd, busy, frame_done, cmd_err});
        end
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({data_even, data_odd, busy, frame_done, cmd_err} !== 5'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got %b expected 00000",
                     {data_even, data_odd, busy, frame_done, cmd_err});
        end
    endtask

    task automatic test_ramp_frame();
        logic [13:0] got, want;
        send(16'h1003, 1'b1);
        checks++;
        if (cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL t1_set_lines_err: got %b expected 0", cmd_err);
        end
        step();
        send(16'h4000, 1'b1);
        checks++;
        if (busy !== 1'b1 || data_even !== 1'b0) begin
            failures++;
            $display("FAIL t1_busy_rise: got busy=%b even=%b expected busy=1 even=0", busy, data_even);
        end
        capture(300, -1);
        for (int l = 0; l < 3; l++) begin
            for (int ln = 0; ln < 2; ln++) begin
                got = word_at(ln, 44 * l);
                checks++;
                if (got !== 14'h3FC0) begin
                    failures++;
                    $display("FAIL t1_sync l=%0d lane=%0d: got %h expected 3fc0", l, ln, got);
                end
                for (int k = 0; k < 2; k++) begin
                    got  = word_at(ln, 44 * l + 14 + 14 * k);
                    want = exp_pix(0, 14'h0, l, 2 * k + ln);
                    checks++;
                    if (got !== want) begin
                        failures++;
                        $display("FAIL t1_pix l=%0d lane=%0d k=%0d: got %h expected %h", l, ln, k, got, want);
                    end
                end
            end
            checks++;
            if ({le[44*l+42], le[44*l+43], lo[44*l+42], lo[44*l+43]} !== 4'b0) begin
                failures++;
                $display("FAIL t1_gap l=%0d: got nonzero expected 0", l);
            end
        end
        checks++;
        if (done_off !== 132 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t1_frame_done: got offset=%0d busy=%b expected offset=132 busy=0", done_off, busy);
        end
        step();
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL t1_done_pulse: got %b expected 0", frame_done);
        end
    endtask

    task automatic test_const_frame();
        logic [13:0] got;
        send(16'h2001, 1'b1);
        send(16'h3ABC, 1'b1);
        step();
        send(16'h4000, 1'b1);
        capture(300, -1);
        for (int l = 0; l < 3; l++)
            for (int ln = 0; ln < 2; ln++)
                for (int k = 0; k < 2; k++) begin
                    got = word_at(ln, 44 * l + 14 + 14 * k);
                    checks++;
                    if (got !== 14'h0ABC) begin
                        failures++;
                        $display("FAIL t2_const l=%0d lane=%0d k=%0d: got %h expected 0abc", l, ln, k, got);
                    end
                end
        checks++;
        if (done_off !== 132) begin
            failures++;
            $display("FAIL t2_frame_len: got %0d expected 132", done_off);
        end
    endtask

    task automatic test_checker_frame();
        logic [13:0] got, want;
        send(16'h2002, 1'b1);
        send(16'h1002, 1'b1);
        step();
        send(16'h4000, 1'b1);
        capture(300, -1);
        for (int l = 0; l < 2; l++)
            for (int ln = 0; ln < 2; ln++)
                for (int k = 0; k < 2; k++) begin
                    got  = word_at(ln, 44 * l + 14 + 14 * k);
                    want = ((l + ln) % 2 == 1) ? 14'h3FFF : 14'h0000;
                    checks++;
                    if (got !== want) begin
                        failures++;
                        $display("FAIL t3_checker l=%0d lane=%0d k=%0d: got %h expected %h", l, ln, k, got, want);
                    end
                end
        checks++;
        if (done_off !== 88) begin
            failures++;
            $display("FAIL t3_frame_len: got %0d expected 88", done_off);
        end
    endtask

    task automatic test_bad_commands();
        logic [15:0] words[4];
        logic        stops[4];
        int          waited;
        words = '{16'h1005, 16'hF000, 16'h1000, 16'h2003};
        stops = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step();
            send(words[i], stops[i]);
            checks++;
            if (cmd_err !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL t4_err case=%0d: got err=%b busy=%b expected err=1 busy=0", i, cmd_err, busy);
            end
            step();
            checks++;
            if (cmd_err !== 1'b0) begin
                failures++;
                $display("FAIL t4_err_pulse case=%0d: got %b expected 0", i, cmd_err);
            end
        end
        step();
        send(16'h4000, 1'b1);
        checks++;
        if (cmd_err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t4_start: got err=%b busy=%b expected err=0 busy=1", cmd_err, busy);
        end
        send(16'h4000, 1'b1);
        checks++;
        if (cmd_err !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t4_start_busy: got err=%b busy=%b expected err=1 busy=1", cmd_err, busy);
        end
        waited = 0;
        while (!frame_done && waited < 300) begin
            step();
            waited++;
        end
        checks++;
        if (18 + waited !== 89) begin
            failures++;
            $display("FAIL t4_lines_kept: got frame end after %0d cycles expected 89", 18 + waited);
        end
    endtask

    task automatic test_stop_cmd();
        logic [13:0] got, want;
        int          activity;
        step();
        send(16'h2000, 1'b1);
        send(16'h1005, 1'b1);
        step();
        send(16'h4000, 1'b1);
        capture(400, 44);
        checks++;
        if (done_off !== 88 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t5_stop_done: got offset=%0d busy=%b expected offset=88 busy=0", done_off, busy);
        end
        for (int l = 0; l < 2; l++)
            for (int ln = 0; ln < 2; ln++)
                for (int k = 0; k < 2; k++) begin
                    got  = word_at(ln, 44 * l + 14 + 14 * k);
                    want = exp_pix(0, 14'h0, l, 2 * k + ln);
                    checks++;
                    if (got !== want) begin
                        failures++;
                        $display("FAIL t5_pix l=%0d lane=%0d k=%0d: got %h expected %h", l, ln, k, got, want);
                    end
                end
        activity = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (data_even || data_odd || busy) activity++;
        end
        checks++;
        if (activity !== 0) begin
            failures++;
            $display("FAIL t5_no_line2: got %0d active cycles expected 0", activity);
        end
    endtask

    task automatic test_interrupts();
        logic [13:0] got, want;
        int          dones, busies;
        send(16'h4000, 1'b1);
        for (int i = 0; i < 20; i++) step();
        ena = 1'b0;
        step();
        checks++;
        if ({data_even, data_odd, busy, frame_done} !== 4'b0) begin
            failures++;
            $display("FAIL t6_ena_drop: got %b expected 0000", {data_even, data_odd, busy, frame_done});
        end
        step();
        step();
        ena = 1'b1;
        dones = 0;
        busies = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (frame_done) dones++;
            if (busy) busies++;
        end
        checks++;
        if (dones !== 0 || busies !== 0) begin
            failures++;
            $display("FAIL t6_ena_idle: got done=%0d busy=%0d expected 0 0", dones, busies);
        end
        send(16'h1004, 1'b1);
        send(16'h2002, 1'b1);
        step();
        send(16'h4000, 1'b1);
        for (int i = 0; i < 10; i++) step();
        cmd = 1'b0;
        step();
        cmd = 1'b1;
        step();
        cmd = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({data_even, data_odd, busy, frame_done, cmd_err} !== 5'b0) begin
            failures++;
            $display("FAIL t6_rst_async: got %b expected 00000", {data_even, data_odd, busy, frame_done, cmd_err});
        end
        step();
        rst = 1'b0;
        cmd = 1'b1;
        step();
        step();
        send(16'h4000, 1'b1);
        checks++;
        if (busy !== 1'b1 || cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL t6_restart: got busy=%b err=%b expected busy=1 err=0", busy, cmd_err);
        end
        capture(300, -1);
        checks++;
        if (done_off !== 44) begin
            failures++;
            $display("FAIL t6_one_line: got %0d expected 44", done_off);
        end
        for (int ln = 0; ln < 2; ln++)
            for (int k = 0; k < 2; k++) begin
                got  = word_at(ln, 14 + 14 * k);
                want = exp_pix(0, 14'h0, 0, 2 * k + ln);
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL t6_ramp lane=%0d k=%0d: got %h expected %h", ln, k, got, want);
                end
            end
    endtask

    initial begin
        test_reset();
        test_ramp_frame();
        test_const_frame();
        test_checker_frame();
        test_bad_commands();
        test_stop_cmd();
        test_interrupts();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
